char_screen_buffer: RTL
=======================

// Module: char_screen_buffer
// PURPOSE
//  Writable character-cell RAM for the VGA text overlay; generalises the fixed label/result lookup.
//  Holds a 2^COLS_LOG2 x 2^ROWS_LOG2 grid of 7-bit ASCII codes.
//  The writer streams characters in through a valid/ready port, with cursor auto-advance and LF/CR handling.
//  The char renderer reads cells by {row,col} address with registered data out.
//  The cell array is initialised and cleared by a hardware sweep, not by reset.
// PARAMETERS
//  COLS_LOG2  4      log2 of columns per row (16)
//  ROWS_LOG2  4      log2 of rows (16)
//  FILL_CHAR  7'h20  code written by clear/scroll sweeps (space)
//  ADDR_W = COLS_LOG2+ROWS_LOG2 (localparam); cell address = {row, col}
// PORTS
//  pclk       in   1       pixel clock; all state on rising edge
//  rst_n      in   1       async active-low reset
//  wr_char    in   7       ASCII code to write at cursor
//  wr_valid   in   1       wr_char valid
//  wr_ready   out  1       accept; handshake = wr_valid & wr_ready
//  clr_req    in   1       one-cycle pulse: clear screen, home cursor
//  busy       out  1       clear/scroll sweep in progress
//  char_xy    in   ADDR_W  renderer read address {row,col}
//  char_code  out  7       cell content, 1-cycle read latency
//  cursor_x   out  COLS_LOG2  current write column
//  cursor_y   out  ROWS_LOG2  current write row
// BEHAVIOUR
//  Reset (async assert, sync release): cursor_x/y=0, char_code=FILL_CHAR, busy=1, wr_ready=0, state=CLEAR, sweep addr=0.
//  FSM states: CLEAR -> IDLE; IDLE -> CLEAR on clr_req; IDLE -> SCROLL (macro only); SCROLL -> IDLE or CLEAR.
//  CLEAR: writes FILL_CHAR to addr 0..2^ADDR_W-1, one cell/cycle (256 cycles at defaults), busy=1, then IDLE.
//  IDLE: busy=0; wr_ready = (state==IDLE) & ~clr_req (combinational).
//  Accepted char handling, by wr_char:
//   - 7'h0A (LF): no store; cursor_x<=0, cursor_y advances.
//   - 7'h0D (CR): no store; cursor_x<=0.
//   - other: mem[{cursor_y,cursor_x}]<=wr_char; cursor_x+1. At cursor_x==max: cursor_x<=0, cursor_y advances.
//  Row advance from the last row:
//   - without macro: wraps to row 0.
//   - with macro: enters SCROLL.
//  clr_req in IDLE: next state CLEAR and cursor<=(0,0); a simultaneous wr_valid is not accepted.
//  clr_req during CLEAR: ignored. clr_req during SCROLL: latched, CLEAR entered when SCROLL ends.
//  Read port: char_code <= mem[char_xy] every cycle, in any state, independent of the write path.
//   - Same-address read/write is read-first (old data).
//   - During sweeps, returned data reflects partially swept contents.
//  Widths: cursor counters wrap naturally at 2^N; all arithmetic is unsigned, with no overflow flags.
//  rst_n low mid-sweep: aborts immediately; sweep restarts at addr 0 after release. Contents until then are undefined.
// CONFIGURATION
//  TEXT_SCROLL_EN defined:
//   - Advancing past the last row enters SCROLL: a pipelined sweep (read a+COLS, write a).
//   - Rows 0..ROWS-2 take the contents of the row below; the last row is filled with FILL_CHAR.
//   - Lasts 2^ADDR_W+1 cycles with busy=1, wr_ready=0; cursor ends at (0, ROWS-1).
//   - Needs a second internal read port.
//  TEXT_SCROLL_EN undefined: no SCROLL state; cursor_y wraps to 0 and old text is overwritten in place.
// TESTING
//  1 Release rst_n -> busy=1 for exactly 256 pclk, then busy=0, wr_ready=1. Reading all 256 addresses gives 7'h20.
//  2 Stream "Result:" (52,65,73,75,6C,74,3A) -> char_xy 8'h00..8'h06 return those codes 1 cycle after address; cursor=(7,0).
//  3 Write 16x 7'h41 from home -> cursor=(0,1). Then 5 chars + LF -> cursor=(0,2), 8'h15 holds 7'h20.
//  4 Cursor at (15,15), write 7'h42:
//    - without macro: cursor=(0,0); next char lands at 8'h00.
//    - with TEXT_SCROLL_EN: busy 257 cycles; row 0 = old row 1; row 14 contains 7'h42 at col 15; row 15 all 7'h20; cursor=(0,15).
//  5 clr_req and wr_valid in same cycle -> wr_ready=0 that cycle, char not stored, 256-cycle clear, cursor=(0,0).
//  6 rst_n low at clear cycle 100 -> char_code=7'h20, cursor=0 immediately; after release a full 256-cycle sweep completes.

Source files
------------

// File: rtl/char_screen_buffer_if.sv
// Write/read bus of the character-cell screen buffer: writer stream, clear request,
// renderer read port and cursor status.
interface char_screen_buffer_if #(
  parameter int COLS_LOG2 = 4,
  parameter int ROWS_LOG2 = 4
);
  localparam int ADDR_W = COLS_LOG2 + ROWS_LOG2;

  logic [6:0]           wr_char;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 clr_req;
  logic                 busy;
  logic [ADDR_W-1:0]    char_xy;
  logic [6:0]           char_code;
  logic [COLS_LOG2-1:0] cursor_x;
  logic [ROWS_LOG2-1:0] cursor_y;

  modport master (
    output wr_char, wr_valid, clr_req, char_xy,
    input  wr_ready, busy, char_code, cursor_x, cursor_y
  );

  modport slave (
    input  wr_char, wr_valid, clr_req, char_xy,
    output wr_ready, busy, char_code, cursor_x, cursor_y
  );
endinterface

// File: rtl/char_screen_buffer.sv
// Writable character-cell RAM for the VGA text overlay with cursor auto-advance,
// LF/CR handling and hardware clear sweep. Optional scrolling: define TEXT_SCROLL_EN.
module char_screen_buffer #(
  parameter int         COLS_LOG2 = 4,
  parameter int         ROWS_LOG2 = 4,
  parameter logic [6:0] FILL_CHAR = 7'h20
) (
  input  logic pclk,
  input  logic rst_n,
  char_screen_buffer_if.slave bus
);

  localparam int ADDR_W = COLS_LOG2 + ROWS_LOG2;
  localparam int CELLS  = 1 << ADDR_W;

  localparam logic [COLS_LOG2-1:0] COL_MAX  = '1;
  localparam logic [ADDR_W-1:0]    ADDR_MAX = '1;
  localparam logic [6:0]           CH_LF    = 7'h0A;
  localparam logic [6:0]           CH_CR    = 7'h0D;

`ifdef TEXT_SCROLL_EN
  localparam logic [ROWS_LOG2-1:0] ROW_MAX     = '1;
  localparam logic [ADDR_W:0]      SCROLL_END  = (ADDR_W+1)'(CELLS);
  localparam logic [ADDR_W:0]      LAST_ROW_AT = (ADDR_W+1)'(CELLS - (1 << COLS_LOG2));
  localparam logic [ADDR_W-1:0]    ROW_STRIDE  = ADDR_W'(1 << COLS_LOG2);

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SCROLL} state_t;
`else
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE} state_t;
`endif

  state_t               state_q, state_d;
  logic [ADDR_W:0]      sweep_q, sweep_d;
  logic [COLS_LOG2-1:0] cur_x_q, cur_x_d;
  logic [ROWS_LOG2-1:0] cur_y_q, cur_y_d;
  logic [6:0]           code_q;

  logic [6:0]           mem [CELLS];
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [6:0]           mem_wdata;

  logic                 wr_ready;
  logic                 accept;
  logic                 row_adv;

`ifdef TEXT_SCROLL_EN
  logic                 clr_pend_q, clr_pend_d;
  logic [ADDR_W:0]      sweep_m1;
  logic [ADDR_W-1:0]    scroll_raddr;
  logic [6:0]           scroll_q;

  assign sweep_m1     = sweep_q - 1'b1;
  assign scroll_raddr = sweep_q[ADDR_W-1:0] + ROW_STRIDE;
`endif

  assign wr_ready = (state_q == ST_IDLE) & ~bus.clr_req;
  assign accept   = bus.wr_valid & wr_ready;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    mem_we    = 1'b0;
    mem_waddr = {cur_y_q, cur_x_q};
    mem_wdata = bus.wr_char;
    row_adv   = 1'b0;
`ifdef TEXT_SCROLL_EN
    clr_pend_d = clr_pend_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q[ADDR_W-1:0];
        mem_wdata = FILL_CHAR;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q[ADDR_W-1:0] == ADDR_MAX) begin
          sweep_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
          cur_x_d = '0;
          cur_y_d = '0;
        end else if (accept) begin
          if (bus.wr_char == CH_LF) begin
            cur_x_d = '0;
            row_adv = 1'b1;
          end else if (bus.wr_char == CH_CR) begin
            cur_x_d = '0;
          end else begin
            mem_we  = 1'b1;
            cur_x_d = cur_x_q + 1'b1;
            row_adv = (cur_x_q == COL_MAX);
          end
          if (row_adv) begin
`ifdef TEXT_SCROLL_EN
            // Leaving the last row scrolls; the cursor stays on that row.
            if (cur_y_q == ROW_MAX) begin
              state_d = ST_SCROLL;
              sweep_d = '0;
            end else begin
              cur_y_d = cur_y_q + 1'b1;
            end
`else
            cur_y_d = cur_y_q + 1'b1;
`endif
          end
        end
      end
`ifdef TEXT_SCROLL_EN
      ST_SCROLL: begin
        // Write lags the row-below read by one cycle, so step 0 only primes scroll_q.
        clr_pend_d = clr_pend_q | bus.clr_req;
        mem_we     = (sweep_q != '0);
        mem_waddr  = sweep_m1[ADDR_W-1:0];
        mem_wdata  = scroll_q;
        sweep_d    = sweep_q + 1'b1;
        if (sweep_q == SCROLL_END) begin
          sweep_d    = '0;
          clr_pend_d = 1'b0;
          if (clr_pend_q | bus.clr_req) begin
            state_d = ST_CLEAR;
            cur_x_d = '0;
            cur_y_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = ST_CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      code_q  <= FILL_CHAR;
`ifdef TEXT_SCROLL_EN
      clr_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      code_q  <= mem[bus.char_xy];
`ifdef TEXT_SCROLL_EN
      clr_pend_q <= clr_pend_d;
`endif
    end
  end

  // Cell array has no reset; the clear sweep initialises it.
  always_ff @(posedge pclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef TEXT_SCROLL_EN
  always_ff @(posedge pclk) begin
    if (state_q == ST_SCROLL) begin
      scroll_q <= (sweep_q < LAST_ROW_AT) ? mem[scroll_raddr] : FILL_CHAR;
    end
  end
`endif

  assign bus.wr_ready  = wr_ready;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.char_code = code_q;
  assign bus.cursor_x  = cur_x_q;
  assign bus.cursor_y  = cur_y_q;

endmodule
